logic_unit_seq: RTL and testbench

- Parametrised, multi-cycle bitwise logic unit for the ALU32 logic path.
- Generalises the fixed 32-bit XOR to WIDTH bits and eight selectable operations.
- Processes operands CHUNK bits per cycle, LSB chunk first, with valid/ready handshakes on input and output.
- Produces a registered result plus a zero flag.

---
 rtl/logic_pkg.sv | 21 ++
 rtl/logic_chunk_op.sv | 29 ++
 rtl/logic_unit_seq.sv | 147 ++++++++++++++
 tb/tb_logic_unit_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared definitions for the sequential logic unit: op encodings and FSM states.
package logic_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND   = 3'b000;
  localparam logic [OP_W-1:0] OP_OR    = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR   = 3'b010;
  localparam logic [OP_W-1:0] OP_NOR   = 3'b011;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_ANDN  = 3'b101;
  localparam logic [OP_W-1:0] OP_PASSA = 3'b110;
  localparam logic [OP_W-1:0] OP_NOTA  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/logic_chunk_op.sv
// Combinational CHUNK-wide bitwise operation; shared by multi-cycle and
// single-cycle logic unit variants.
module logic_chunk_op
  import logic_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [CHUNK-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_XOR:   y = a ^ b;
      OP_NOR:   y = ~(a | b);
      OP_XNOR:  y = ~(a ^ b);
      OP_ANDN:  y = a & ~b;
      OP_PASSA: y = a;
      OP_NOTA:  y = ~a;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit, CHUNK bits per cycle LSB first, with
// valid/ready handshakes. Define LOGIC_UNIT_PARITY_EN to add a parity output.
module logic_unit_seq
  import logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef LOGIC_UNIT_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
    $fatal(1, "logic_unit_seq: WIDTH must be a nonzero multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic             zero_acc_q, zero_acc_d, zero_q, zero_d;
  logic [CHUNK-1:0] a_chunk, b_chunk, y_chunk;
`ifdef LOGIC_UNIT_PARITY_EN
  logic             parity_acc_q, parity_acc_d, parity_q, parity_d;
`endif

  assign a_chunk = a_q[cnt_q*CHUNK +: CHUNK];
  assign b_chunk = b_q[cnt_q*CHUNK +: CHUNK];

  logic_chunk_op #(.CHUNK(CHUNK)) u_chunk_op (
    .op (op_q),
    .a  (a_chunk),
    .b  (b_chunk),
    .y  (y_chunk)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    zero_acc_d = zero_acc_q;
    zero_d     = zero_q;
`ifdef LOGIC_UNIT_PARITY_EN
    parity_acc_d = parity_acc_q;
    parity_d     = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d       = op;
          a_d        = a;
          b_d        = b;
          result_d   = '0;
          zero_acc_d = 1'b1;
          cnt_d      = '0;
`ifdef LOGIC_UNIT_PARITY_EN
          parity_acc_d = 1'b0;
`endif
          state_d    = RUN;
        end
      end
      RUN: begin
        result_d[cnt_q*CHUNK +: CHUNK] = y_chunk;
        zero_acc_d = zero_acc_q & (y_chunk == '0);
`ifdef LOGIC_UNIT_PARITY_EN
        parity_acc_d = parity_acc_q ^ (^y_chunk);
`endif
        // Flags are published only once the final chunk has been folded in.
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          zero_d  = zero_acc_d;
`ifdef LOGIC_UNIT_PARITY_EN
          parity_d = parity_acc_d;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      zero_acc_q <= 1'b0;
      zero_q     <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
      parity_acc_q <= 1'b0;
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      zero_acc_q <= zero_acc_d;
      zero_q     <= zero_d;
`ifdef LOGIC_UNIT_PARITY_EN
      parity_acc_q <= parity_acc_d;
      parity_q     <= parity_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
`ifdef LOGIC_UNIT_PARITY_EN
  assign parity    = parity_q;
`endif

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed self-checking bench for logic_unit_seq: 32/8, 64/16 and 8/8 instances
// share stimulus buses; sel chooses which instance a request targets.
module tb_logic_unit_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  op_i = 3'b000;
  logic [63:0] a_i = '0;
  logic [63:0] b_i = '0;
  int          sel = 0;

  logic        iv32, iv64, iv8;
  logic        rdy32, rdy64, rdy8;
  logic        ov32, ov64, ov8;
  logic        z32, z64, z8;
  logic [31:0] res32;
  logic [63:0] res64;
  logic [7:0]  res8;
`ifdef LOGIC_UNIT_PARITY_EN
  logic        p32, p64, p8, p_m;
`endif

  logic        rdy_m, ov_m, z_m;
  logic [63:0] res_m;

  int total = 0;
  int bad = 0;
  int accepts = 0;
  int dones = 0;

  always #5 clk = ~clk;

  assign iv32 = in_valid && (sel == 0);
  assign iv64 = in_valid && (sel == 1);
  assign iv8  = in_valid && (sel == 2);

  logic_unit_seq #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy32), .op(op_i),
    .a(a_i[31:0]), .b(b_i[31:0]), .out_valid(ov32), .out_ready(out_ready),
    .result(res32), .zero(z32)
`ifdef LOGIC_UNIT_PARITY_EN
    , .parity(p32)
`endif
  );

  logic_unit_seq #(.WIDTH(64), .CHUNK(16)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(rdy64), .op(op_i),
    .a(a_i), .b(b_i), .out_valid(ov64), .out_ready(out_ready),
    .result(res64), .zero(z64)
`ifdef LOGIC_UNIT_PARITY_EN
    , .parity(p64)
`endif
  );

  logic_unit_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .op(op_i),
    .a(a_i[7:0]), .b(b_i[7:0]), .out_valid(ov8), .out_ready(out_ready),
    .result(res8), .zero(z8)
`ifdef LOGIC_UNIT_PARITY_EN
    , .parity(p8)
`endif
  );

  always_comb begin
    rdy_m = rdy32;
    ov_m  = ov32;
    z_m   = z32;
    res_m = {32'b0, res32};
`ifdef LOGIC_UNIT_PARITY_EN
    p_m   = p32;
`endif
    if (sel == 1) begin
      rdy_m = rdy64;
      ov_m  = ov64;
      z_m   = z64;
      res_m = res64;
`ifdef LOGIC_UNIT_PARITY_EN
      p_m   = p64;
`endif
    end else if (sel == 2) begin
      rdy_m = rdy8;
      ov_m  = ov8;
      z_m   = z8;
      res_m = {56'b0, res8};
`ifdef LOGIC_UNIT_PARITY_EN
      p_m   = p8;
`endif
    end
  end

  // Handshake counters sample mid-cycle, where all inputs and outputs are settled.
  always begin
    @(negedge clk);
    #4;
    if (in_valid && rdy_m) accepts++;
    if (ov_m && out_ready) dones++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one request, holds it through the accept edge, then optionally keeps
  // in_valid high with scrambled operands to prove they are ignored in flight.
  task automatic applyStimulus(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                               input bit scramble);
    @(negedge clk);
    op_i = op;
    a_i = a;
    b_i = b;
    in_valid = 1'b1;
    check("ready_before_accept", rdy_m, 1'b1);
    @(posedge clk);
    #1;
    if (scramble) begin
      op_i = ~op;
      a_i = ~a;
      b_i = ~b;
    end else begin
      in_valid = 1'b0;
    end
    check("busy_after_accept", rdy_m, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] exp_res, input logic exp_zero,
                             input int exp_lat, input int hold);
    int lat;
    lat = 0;
    while (!ov_m && lat < 16) begin
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, res_m, exp_res);
    check({tag, "_zero"}, z_m, exp_zero);
`ifdef LOGIC_UNIT_PARITY_EN
    check({tag, "_parity"}, p_m, ^exp_res);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, ov_m, 1'b1);
      check({tag, "_hold_result"}, res_m, exp_res);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_consumed"}, ov_m, 1'b0);
    check({tag, "_idle_ready"}, rdy_m, 1'b1);
    check({tag, "_result_held"}, res_m, exp_res);
  endtask

  logic [31:0] sweep_exp [8];

  initial begin
    sweep_exp[0] = 32'h00005678;
    sweep_exp[1] = 32'h1234FFFF;
    sweep_exp[2] = 32'h1234A987;
    sweep_exp[3] = 32'hEDCB0000;
    sweep_exp[4] = 32'hEDCB5678;
    sweep_exp[5] = 32'h12340000;
    sweep_exp[6] = 32'h12345678;
    sweep_exp[7] = 32'hEDCBA987;

    #1 rst = 1'b1;
    #2;
    check("rst_in_ready", rdy32, 1'b1);
    check("rst_out_valid", ov32, 1'b0);
    check("rst_result", {32'b0, res32}, 64'h0);
    check("rst_zero", z32, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    sel = 0;
    applyStimulus(3'b010, 64'hFFFF0000, 64'h0F0F0F0F, 1'b0);
    checkOutput("xor", 64'hF0F00F0F, 1'b0, 4, 0);

    applyStimulus(3'b000, 64'hAAAAAAAA, 64'h55555555, 1'b0);
    checkOutput("and_hold", 64'h0, 1'b1, 4, 5);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(3'(i), 64'h12345678, 64'h0000FFFF, 1'b1);
      checkOutput($sformatf("sweep_op%0d", i), {32'b0, sweep_exp[i]}, 1'b0, 4, 0);
    end

    applyStimulus(3'b001, 64'h0F0F00F0, 64'h0000000F, 1'b0);
    @(posedge clk);
    #1;
    check("or_partial_result", res_m, 64'h000000FF);
    rst = 1'b1;
    #1;
    check("midrun_rst_ready", rdy32, 1'b1);
    check("midrun_rst_valid", ov32, 1'b0);
    check("midrun_rst_result", {32'b0, res32}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(3'b001, 64'h0F0F0000, 64'h000000F0, 1'b0);
    checkOutput("or_after_rst", 64'h0F0F00F0, 1'b0, 4, 0);

    applyStimulus(3'b010, 64'h00000001, 64'h0, 1'b0);
    checkOutput("parity_one", 64'h1, 1'b0, 4, 0);

    sel = 1;
    applyStimulus(3'b010, 64'h0123456789ABCDEF, 64'hFFFFFFFF00000000, 1'b0);
    checkOutput("w64_xor", 64'hFEDCBA9889ABCDEF, 1'b0, 4, 0);
    applyStimulus(3'b101, 64'h0123456789ABCDEF, 64'h00000000FFFFFFFF, 1'b1);
    checkOutput("w64_andn", 64'h0123456700000000, 1'b0, 4, 0);

    sel = 2;
    applyStimulus(3'b000, 64'hF0, 64'h0F, 1'b0);
    checkOutput("w8_and", 64'h0, 1'b1, 1, 0);
    applyStimulus(3'b111, 64'h5A, 64'h00, 1'b0);
    checkOutput("w8_nota", 64'hA5, 1'b0, 1, 0);

    @(negedge clk);
    check("accept_count", 64'(accepts), 64'd17);
    check("done_count", 64'(dones), 64'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
